lieat_exu_vpu_disp: RTL

- In-order VPU dispatch unit: the issue-side counterpart of the VPU writeback merge.
- Accepts decoded vector instructions from the EXU issue stage into a small FIFO.
- Routes the head entry to the vset, vint or vlsu unit over one shared payload bus with per-unit valid/ready.
- Tracks outstanding operations per unit via writeback-handshake taps. Never issues to a unit while a different unit has work in flight, because the writeback merge uses fixed priority (vlsu > vint > vset) and would otherwise retire out of order.

---
 rtl/lieat_exu_vpu_disp.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lieat_exu_vpu_disp.sv
// In-order VPU dispatch: buffers decoded vector instructions and issues the
// head entry to vset/vint/vlsu, never letting two units have work in flight
// at once so the fixed-priority writeback merge retires in program order.
module lieat_exu_vpu_disp #(
    parameter int XLEN       = 32,
    parameter int REG_IDX    = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int OST_W      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vpu_i_valid,
    output logic               vpu_i_ready,
    input  logic [XLEN-1:0]    vpu_i_pc,
    input  logic [31:0]        vpu_i_instr,
    input  logic [1:0]         vpu_i_unit,
    input  logic [REG_IDX-1:0] vpu_i_rd,
    input  logic [XLEN-1:0]    vpu_i_src1,
    input  logic [XLEN-1:0]    vpu_i_src2,
    output logic               vset_i_valid,
    output logic               vint_i_valid,
    output logic               vlsu_i_valid,
    input  logic               vset_i_ready,
    input  logic               vint_i_ready,
    input  logic               vlsu_i_ready,
    output logic [XLEN-1:0]    disp_o_pc,
    output logic [31:0]        disp_o_instr,
    output logic [REG_IDX-1:0] disp_o_rd,
    output logic [XLEN-1:0]    disp_o_src1,
    output logic [XLEN-1:0]    disp_o_src2,
    input  logic               vset_wb_fire,
    input  logic               vint_wb_fire,
    input  logic               vlsu_wb_fire,
    output logic               vpu_o_illegal,
    output logic [XLEN-1:0]    vpu_o_illegal_pc,
    output logic               vpu_o_busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [OST_W-1:0] OST_ONE  = OST_W'(1);

    typedef enum logic [1:0] {
        UNIT_VSET = 2'b00,
        UNIT_VINT = 2'b01,
        UNIT_VLSU = 2'b10,
        UNIT_ILL  = 2'b11
    } unit_e;

    // Instruction buffer storage
    logic [XLEN-1:0]    pc_mem    [FIFO_DEPTH];
    logic [31:0]        instr_mem [FIFO_DEPTH];
    unit_e              unit_mem  [FIFO_DEPTH];
    logic [REG_IDX-1:0] rd_mem    [FIFO_DEPTH];
    logic [XLEN-1:0]    src1_mem  [FIFO_DEPTH];
    logic [XLEN-1:0]    src2_mem  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] occ_q;

    // Outstanding counters, index 0 vset, 1 vint, 2 vlsu
    logic [OST_W-1:0] ost_q [3];

    logic             illegal_q;
    logic [XLEN-1:0]  illegal_pc_q;

    logic       empty;
    logic       full;
    logic       enq;
    logic       deq;
    logic       drop;
    unit_e      head_unit;
    logic [2:0] elig;
    logic [2:0] fire;
    logic [2:0] dec;
    logic [2:0] ost_zero;
    logic [2:0] ost_max;
    logic [2:0] unit_ready;
    logic [2:0] wb_fire;

    // Head decode, per-unit eligibility and handshake qualification
    always_comb begin
        empty      = (occ_q == '0);
        full       = (occ_q == FULL_CNT);
        head_unit  = unit_mem[rd_ptr_q];
        unit_ready = {vlsu_i_ready, vint_i_ready, vset_i_ready};
        wb_fire    = {vlsu_wb_fire, vint_wb_fire, vset_wb_fire};
        ost_zero   = '0;
        ost_max    = '0;
        dec        = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            ost_zero[i] = (ost_q[i] == '0);
            ost_max[i]  = (ost_q[i] == '1);
            // A writeback tap with nothing outstanding is ignored
            dec[i]      = wb_fire[i] && !ost_zero[i];
        end
        elig[0] = !empty && (head_unit == UNIT_VSET) && !ost_max[0] && ost_zero[1] && ost_zero[2];
        elig[1] = !empty && (head_unit == UNIT_VINT) && !ost_max[1] && ost_zero[0] && ost_zero[2];
        elig[2] = !empty && (head_unit == UNIT_VLSU) && !ost_max[2] && ost_zero[0] && ost_zero[1];
        drop    = !empty && (head_unit == UNIT_ILL);
        fire    = elig & unit_ready;
        enq     = vpu_i_valid && !full;
        deq     = (|fire) || drop;
    end

    assign vpu_i_ready  = !full;
    assign vset_i_valid = elig[0];
    assign vint_i_valid = elig[1];
    assign vlsu_i_valid = elig[2];

    assign disp_o_pc    = empty ? '0 : pc_mem[rd_ptr_q];
    assign disp_o_instr = empty ? '0 : instr_mem[rd_ptr_q];
    assign disp_o_rd    = empty ? '0 : rd_mem[rd_ptr_q];
    assign disp_o_src1  = empty ? '0 : src1_mem[rd_ptr_q];
    assign disp_o_src2  = empty ? '0 : src2_mem[rd_ptr_q];

    assign vpu_o_illegal    = illegal_q;
    assign vpu_o_illegal_pc = illegal_pc_q;
    assign vpu_o_busy       = !empty || !(&ost_zero);

    // Buffer storage write; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr_q]    <= vpu_i_pc;
            instr_mem[wr_ptr_q] <= vpu_i_instr;
            unit_mem[wr_ptr_q]  <= unit_e'(vpu_i_unit);
            rd_mem[wr_ptr_q]    <= vpu_i_rd;
            src1_mem[wr_ptr_q]  <= vpu_i_src1;
            src2_mem[wr_ptr_q]  <= vpu_i_src2;
        end
    end

    // Buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (enq) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (enq && !deq) begin
                occ_q <= occ_q + CNT_ONE;
            end else if (deq && !enq) begin
                occ_q <= occ_q - CNT_ONE;
            end
        end
    end

    // Per-unit outstanding counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                ost_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (fire[i] && !dec[i]) begin
                    ost_q[i] <= ost_q[i] + OST_ONE;
                end else if (dec[i] && !fire[i]) begin
                    ost_q[i] <= ost_q[i] - OST_ONE;
                end
            end
        end
    end

    // Illegal-drop pulse and sticky pc of the last dropped entry
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q    <= 1'b0;
            illegal_pc_q <= '0;
        end else begin
            illegal_q <= drop;
            if (drop) begin
                illegal_pc_q <= pc_mem[rd_ptr_q];
            end
        end
    end

endmodule
